// File: rtl/fir_seq_mac.sv
// TAPS-tap signed FIR filter built around one time-shared multiply-accumulate, with runtime-loadable coefficients.
// Define FIR_SATURATE_EN to clamp the output to the DW-bit range; when it is undefined the output wraps.
module fir_seq_mac #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int TAPS  = 4,
    parameter int SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DW-1:0]      in,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]      coef_data,
    output logic                      out_valid,
    output logic signed [DW-1:0]      out
);

    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = DW + CW + $clog2(TAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic signed [CW-1:0] C_UNITY = CW'(1 << SHIFT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic signed [DW-1:0]      r_x [TAPS];
    logic signed [CW-1:0]      r_c [TAPS];
    logic signed [ACCW-1:0]    r_acc;
    logic [AW-1:0]             r_idx;
    logic signed [DW-1:0]      r_out;
    logic                      r_out_valid;

    logic signed [DW+CW-1:0]   w_prod;
    logic signed [ACCW-1:0]    w_prod_ext;
    logic signed [ACCW:0]      w_round;
    logic signed [ACCW:0]      w_r;
    logic signed [DW-1:0]      w_fmt;
    logic                      w_coef_ok;

    assign in_ready  = en && (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign out       = r_out;

    // Zero-extend before comparing so non-power-of-two TAPS rejects unused addresses.
    assign w_coef_ok = ({1'b0, coef_addr} < (AW+1)'(TAPS));

    assign w_prod     = r_x[r_idx] * r_c[r_idx];
    assign w_prod_ext = {{(ACCW-DW-CW){w_prod[DW+CW-1]}}, w_prod};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACCW:0] HALF = (ACCW+1)'(1) <<< (SHIFT - 1);
            assign w_round = {r_acc[ACCW-1], r_acc} + HALF;
        end else begin : g_noround
            assign w_round = {r_acc[ACCW-1], r_acc};
        end
    endgenerate

    assign w_r = w_round >>> SHIFT;

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [ACCW:0] SAT_MIN = -SAT_MAX - (ACCW+1)'(1);

    always_comb begin
        w_fmt = DW'(w_r);
        if (w_r > SAT_MAX) begin
            w_fmt = DW'(SAT_MAX);
        end else if (w_r < SAT_MIN) begin
            w_fmt = DW'(SAT_MIN);
        end
    end
`else
    assign w_fmt = DW'(w_r);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_MAC;
            ST_MAC:  if (r_idx == LAST_IDX) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
                r_c[k] <= '0;
            end
            r_c[0]      <= C_UNITY;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (en) begin
            r_out_valid <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (coef_we && w_coef_ok) begin
                        r_c[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        for (int unsigned k = 1; k < TAPS; k++) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0] <= in;
                        r_acc  <= '0;
                        r_idx  <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + AW'(1);
                end
                ST_DONE: begin
                    r_out <= w_fmt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Bench for fir_seq_mac: directed cases with literal expectations plus randomized traffic,
// all checked every cycle against a sample-history / coefficient-table model of the filter.
module tb_fir_seq_mac;

    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int TAPS  = 4;
    localparam int SHIFT = 3;
    localparam int AW    = $clog2(TAPS);

    logic                     clk;
    logic                     rst;
    logic                     en;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DW-1:0]     in;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [CW-1:0]     coef_data;
    logic                     out_valid;
    logic signed [DW-1:0]     out;

    fir_seq_mac #(
        .DW    (DW),
        .CW    (CW),
        .TAPS  (TAPS),
        .SHIFT (SHIFT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: sample history, coefficient table, and remaining enabled edges until the result appears.
    int  mx [TAPS];
    int  mc [TAPS];
    int  m_pend;
    int  m_result;
    int  m_out;
    bit  m_ov;
    bit  known = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int fmt(input longint acc);
        longint den;
        longint num;
        longint r;
        den = longint'(1) << SHIFT;
        num = acc + den / 2;
        r   = num / den;
        if ((num % den != 0) && (num < 0)) r = r - 1;
`ifdef FIR_SATURATE_EN
        if (r > (1 << (DW-1)) - 1) r = (1 << (DW-1)) - 1;
        if (r < -(1 << (DW-1)))    r = -(1 << (DW-1));
        return int'(r);
`else
        r = r & ((longint'(1) << DW) - 1);
        if (r >= (longint'(1) << (DW-1))) r = r - (longint'(1) << DW);
        return int'(r);
`endif
    endfunction

    function automatic int filter_now();
        longint acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'(mx[k]) * longint'(mc[k]);
        return fmt(acc);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            mx[k] = 0;
            mc[k] = 0;
        end
        mc[0]    = 1 << SHIFT;
        m_pend   = 0;
        m_result = 0;
        m_out    = 0;
        m_ov     = 1'b0;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic step();
        #1;
        if (known) check("in_ready", int'(in_ready), (en && m_pend == 0) ? 1 : 0);
        if (rst) begin
            model_reset();
        end else if (en) begin
            m_ov = 1'b0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_ov  = 1'b1;
                    m_out = m_result;
                end
            end else begin
                if (coef_we && int'(coef_addr) < TAPS) mc[coef_addr] = int'(coef_data);
                if (in_valid) begin
                    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
                    mx[0]    = int'(in);
                    m_result = filter_now();
                    m_pend   = TAPS + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) known = 1'b1;
        if (known) begin
            check("out_valid", int'(out_valid), int'(m_ov));
            check("out", int'(out), m_out);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = CW'(data);
        step();
        coef_we   = 1'b0;
    endtask

    task automatic send(input int s, input string nm, input int exp_val);
        int guard = 0;
        int lat   = 0;
        in       = DW'(s);
        in_valid = 1'b1;
        while (m_pend != 0 && guard < 40) begin
            step();
            guard++;
        end
        step();
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({nm, "_latency"}, lat, TAPS + 1);
        check(nm, int'(out), exp_val);
    endtask

    initial begin
        int lat;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();

        // Reset defaults and unity pass-through (c0 = 1<<SHIFT).
        do_reset();
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        send(-8, "t1_neg8", -8);
        send(24, "t1_24", 24);

        // Impulse through c = {1,2,3,4} scaled by 1<<SHIFT.
        do_reset();
        for (int a = 0; a < TAPS; a++) write_coef(a, (a + 1) << SHIFT);
        send(5, "t2_y0", 5);
        send(0, "t2_y1", 10);
        send(0, "t2_y2", 15);
        send(0, "t2_y3", 20);
        send(0, "t2_y4", 0);

        // Large accumulator: 100*127 = 12700 -> 1588 after rounding shift.
        do_reset();
        for (int a = 0; a < TAPS; a++) write_coef(a, 127);
`ifdef FIR_SATURATE_EN
        send(100, "t3_big", 127);
`else
        send(100, "t3_big", 52);
`endif

        // Round half up at the SHIFT boundary.
        do_reset();
        write_coef(0, 1);
        send(4, "t4_half", 1);
        send(3, "t4_below_half", 0);

        // Clock-enable stall mid-MAC and a dropped coefficient write.
        do_reset();
        in = DW'(16);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        coef_we = 1'b1; coef_addr = '0; coef_data = '0;
        step();
        coef_we = 1'b0;
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        lat = 8;
        while (!out_valid && lat < 60) begin
            step();
            lat++;
        end
        check("t5_stall_latency", lat, TAPS + 1 + 5);
        check("t5_stall_out", int'(out), 16);
        send(16, "t5_coef_kept", 16);

        // Reset during MAC discards the pending result and restores identity coefficients.
        do_reset();
        write_coef(0, 3);
        write_coef(1, 5);
        send(20, "t6_pre", 8);
        in = DW'(40);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_ready", int'(in_ready), 1);
        check("t6_out", int'(out), 0);
        check("t6_out_valid", int'(out_valid), 0);
        repeat (8) step();
        send(40, "t6_identity", 40);

        // Randomized traffic: enable gaps, writes in any state, occasional resets.
        do_reset();
        repeat (3000) begin
            rst       = ($urandom_range(0, 199) == 0);
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in        = DW'($urandom);
            coef_we   = ($urandom_range(0, 4) == 0);
            coef_addr = AW'($urandom);
            coef_data = CW'($urandom);
            step();
        end
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
        repeat (TAPS + 3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
